// File: rtl/booth_dsp_pkg.sv
// Shared DSP definitions for the Booth multiplier datapath and its downstream stages.
// Holds default widths, the accumulator FSM state type, and the width-generic
// sign-extension / saturation helpers used by the adders.
package booth_dsp_pkg;

  localparam int PROD_W_DEF = 128;
  localparam int ACC_W_DEF  = 136;

  // Helpers work on a fixed wide word; callers slice out the bits they need.
  localparam int MAX_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Replicate bit (from_w-1) of v into all higher bits.
  function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v,
                                                   input int              from_w);
    logic signed [MAX_W-1:0] t;
    t = $signed(v << (MAX_W - from_w));
    return t >>> (MAX_W - from_w);
  endfunction

  // Most positive (neg=0) or most negative (neg=1) value of a w-bit signed word,
  // valid in bits [w-1:0] of the result.
  function automatic logic [MAX_W-1:0] saturate(input logic neg, input int w);
    logic [MAX_W-1:0] ones;
    logic [MAX_W-1:0] pos_max;
    ones    = '1;
    pos_max = ones >> (MAX_W - w + 1);
    return neg ? ~pos_max : pos_max;
  endfunction

endpackage

// File: rtl/booth_sat_adder.sv
// Signed accumulate adder: acc + sign-extended product at ACC_W+1 bits, overflow flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; optional clamping on overflow when BOOTH_ACC_SAT_EN is defined.
module booth_sat_adder
  import booth_dsp_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [MAX_W-1:0] ext_w;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_full;
  logic             unused_ext_hi;

  assign ext_w         = sign_extend(MAX_W'(prod_i), PROD_W);
  assign prod_ext      = ext_w[ACC_W-1:0];
  assign unused_ext_hi = ^ext_w[MAX_W-1:ACC_W];

  // One extra bit of headroom so the true sign of the sum is always known.
  assign sum_full = {acc_i[ACC_W-1], acc_i} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf_o    = sum_full[ACC_W] ^ sum_full[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
  logic [MAX_W-1:0] sat_w;
  logic             unused_sat_hi;

  assign sat_w         = saturate(sum_full[ACC_W], ACC_W);
  assign unused_sat_hi = ^sat_w[MAX_W-1:ACC_W];

  // Clamp toward the sign of the unbounded sum when it does not fit ACC_W bits.
  always_comb begin
    sum_o = sum_full[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = sat_w[ACC_W-1:0];
    end
  end
`else
  // Wrap modulo 2^ACC_W; the overflow flag still reports the event.
  always_comb begin
    sum_o = sum_full[ACC_W-1:0];
  end
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Frame accumulator for the Booth product stream; one sum/count/overflow result per frame.
// Latency: result visible the cycle after the in_last handshake.
// Backpressure: in_ready = !out_valid || out_ready; result held stable while stalled.
// Optional build macro BOOTH_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module booth_product_accumulator
  import booth_dsp_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             res_vld_q, res_vld_d;
  logic [ACC_W-1:0] res_acc_q, res_acc_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  logic [ACC_W-1:0] sum;
  logic             term_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  booth_sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .sum_o  (sum),
    .ovf_o  (term_ovf)
  );

  // A term may only enter when the result register is free or draining this edge,
  // so a last term can always publish without dropping an unconsumed result.
  assign in_ready = !res_vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state: clear dominates, then term acceptance, then result drain.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_vld_d = res_vld_q && !out_ready;
    res_acc_d = res_acc_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;

    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      res_vld_d = 1'b0;
    end else if (accept) begin
      if (in_last) begin
        // Publishing overwrites the register; any previous result drains on this edge.
        res_vld_d = 1'b1;
        res_acc_d = sum;
        res_cnt_d = cnt_inc;
        res_ovf_d = ovf_q | term_ovf;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | term_ovf;
      end

      case (state_q)
        IDLE:    state_d = in_last ? IDLE : RUN;
        RUN:     state_d = in_last ? IDLE : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state and result register, cleared asynchronously.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_vld_q <= 1'b0;
      res_acc_q <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_vld_q <= res_vld_d;
      res_acc_q <= res_acc_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign out_valid = res_vld_q;
  assign out_acc   = res_acc_q;
  assign out_count = res_cnt_q;
  assign out_ovf   = res_ovf_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench: two instances (default 136-bit accumulator and 128-bit accumulator)
// share one directed stimulus stream; expected frame results are queued by the driver
// and checked by an independent monitor on each output handshake.
module tb_booth_product_accumulator;

  logic         Clk;
  logic         Reset;
  logic         clear;
  logic         in_valid;
  logic [127:0] in_prod;
  logic         in_last;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [135:0] out_acc_a;
  logic [15:0]  out_count_a;

  logic         in_ready_n, out_valid_n, out_ovf_n, busy_n;
  logic [127:0] out_acc_n;
  logic [15:0]  out_count_n;

  booth_product_accumulator u_dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_acc   (out_acc_a),
    .out_count (out_count_a),
    .out_ovf   (out_ovf_a),
    .busy      (busy_a)
  );

  booth_product_accumulator #(
    .PROD_W (128),
    .ACC_W  (128),
    .CNT_W  (16)
  ) u_dut_n (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_n),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid_n),
    .out_ready (out_ready),
    .out_acc   (out_acc_n),
    .out_count (out_count_n),
    .out_ovf   (out_ovf_n),
    .busy      (busy_n)
  );

  typedef struct {
    logic [135:0] a136;
    logic [127:0] a128;
    logic [15:0]  cnt;
    logic         o136;
    logic         o128;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [135:0] a136, input logic [127:0] a128,
                      input logic [15:0] cnt, input logic o136, input logic o128);
    exp_t e;
    e.a136 = a136; e.a128 = a128; e.cnt = cnt; e.o136 = o136; e.o128 = o128;
    q.push_back(e);
  endtask

  // Present one term and hold it until accepted (bounded); returns at posedge+1.
  task automatic send(input logic [127:0] p, input logic l);
    int   n;
    logic took;
    n = 0; took = 1'b0;
    in_valid = 1'b1; in_prod = p; in_last = l;
    while (!took && n < 50) begin
      @(negedge Clk);
      took = in_ready_a;
      @(posedge Clk);
      n++;
    end
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("accept", took, 1'b1);
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Reset && out_valid_a && out_ready) begin
        if (q.size() == 0) begin
          bad++; total++;
          $display("FAIL unexpected_result: got acc=%0h want no result", out_acc_a);
        end else begin
          e = q.pop_front();
          chk("acc136", out_acc_a, e.a136);
          chk("cnt136", out_count_a, e.cnt);
          chk("ovf136", out_ovf_a, e.o136);
          chk("vld128", out_valid_n, 1'b1);
          chk("acc128", out_acc_n, e.a128);
          chk("cnt128", out_count_n, e.cnt);
          chk("ovf128", out_ovf_n, e.o128);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p126;
    logic [135:0] e_ovf136;
    logic [127:0] e_ovf128;
    p126     = 128'h1 << 126;
    e_ovf136 = 136'h1 << 128;
`ifdef BOOTH_ACC_SAT_EN
    e_ovf128 = {1'b0, {127{1'b1}}};
`else
    e_ovf128 = '0;
`endif

    Reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready_a, 1'b1);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_out_acc", out_acc_a, 136'd0);
    chk("rst_out_count", out_count_a, 16'd0);
    chk("rst_out_ovf", out_ovf_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;

    // Frame 10, -4, 7.
    push(136'd13, 128'd13, 16'd3, 1'b0, 1'b0);
    send(128'd10, 1'b0);
    chk("f1_busy_first", busy_a, 1'b1);
    send(-128'd4, 1'b0);
    send(128'd7, 1'b1);
    chk("f1_busy_after", busy_a, 1'b0);
    chk("f1_latency_vld", out_valid_a, 1'b1);

    // Single term -1.
    push({136{1'b1}}, {128{1'b1}}, 16'd1, 1'b0, 1'b0);
    send({128{1'b1}}, 1'b1);
    chk("f2_idle", busy_a, 1'b0);
    @(posedge Clk); #1;

    // Backpressure: result 20 pending, next term must wait.
    out_ready = 1'b0;
    push(136'd20, 128'd20, 16'd1, 1'b0, 1'b0);
    send(128'd20, 1'b1);
    in_valid = 1'b1; in_prod = 128'd3; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bp_in_ready", in_ready_a, 1'b0);
      chk("bp_in_ready_n", in_ready_n, 1'b0);
      chk("bp_out_valid", out_valid_a, 1'b1);
      chk("bp_out_acc_stable", out_acc_a, 136'd20);
      chk("bp_not_busy", busy_a, 1'b0);
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_release_ready", in_ready_a, 1'b1);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted_busy", busy_a, 1'b1);
    chk("bp_drained", out_valid_a, 1'b0);
    push(136'd7, 128'd7, 16'd2, 1'b0, 1'b0);
    send(128'd4, 1'b1);

    // Overflow of the 128-bit accumulator: four times 2^126.
    push(e_ovf136, e_ovf128, 16'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(p126, (i == 3));

    // Clear mid-frame; the discarded term carries in_last.
    send(128'd5, 1'b0);
    send(128'd6, 1'b0);
    chk("clr_busy_before", busy_a, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_prod = 128'd100; in_last = 1'b1;
    @(posedge Clk); #1;
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("clr_busy_after", busy_a, 1'b0);
    chk("clr_no_result", out_valid_a, 1'b0);
    push(136'd1, 128'd1, 16'd1, 1'b0, 1'b0);
    send(128'd1, 1'b1);
    @(posedge Clk); #1;

    // Asynchronous reset with a result pending, then mid-frame.
    out_ready = 1'b0;
    send(128'd9, 1'b1);
    chk("rst2_pending", out_valid_a, 1'b1);
    #3 Reset = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid_a, 1'b0);
    chk("rst2_in_ready", in_ready_a, 1'b1);
    chk("rst2_out_acc", out_acc_a, 136'd0);
    chk("rst2_out_count", out_count_a, 16'd0);
    chk("rst2_out_ovf", out_ovf_a, 1'b0);
    @(posedge Clk); #1 Reset = 1'b1;
    out_ready = 1'b1;
    send(128'd8, 1'b0);
    chk("rst3_busy_before", busy_a, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk("rst3_busy", busy_a, 1'b0);
    chk("rst3_busy_n", busy_n, 1'b0);
    @(posedge Clk); #1 Reset = 1'b1;
    push(136'd2, 128'd2, 16'd1, 1'b0, 1'b0);
    send(128'd2, 1'b1);

    repeat (5) @(posedge Clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
